// File: rtl/iob_acc_arb.sv
// Round-robin arbiter sharing one accumulator among N_REQ job streams.
// Define IOB_ACC_ARB_SATURATE_EN to clamp on overflow instead of wrapping.
module iob_acc_arb #(
    parameter int N_REQ  = 4,
    parameter int INCR_W = 8,
    parameter int DATA_W = 16,
    parameter int ID_W   = $clog2(N_REQ)
) (
    input  logic                    clk_i,
    input  logic                    cke_i,
    input  logic                    arst_n_i,
    input  logic [N_REQ-1:0]        req_valid_i,
    input  logic [N_REQ-1:0]        req_last_i,
    input  logic [N_REQ*INCR_W-1:0] req_incr_i,
    output logic [N_REQ-1:0]        req_ready_o,
    output logic                    res_valid_o,
    input  logic                    res_ready_i,
    output logic [DATA_W-1:0]       res_data_o,
    output logic [ID_W-1:0]         res_id_o,
    output logic                    res_ovf_o,
    output logic                    busy_o
);

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [ID_W-1:0]     owner_q, owner_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic                ovf_q, ovf_d;

    logic [ID_W-1:0]     pick;
    logic                found;
    logic [ID_W:0]       cand;
    logic                own_valid;
    logic                own_last;
    logic [INCR_W-1:0]   own_incr;
    logic [DATA_W:0]     sum;

    assign own_valid = req_valid_i[owner_q];
    assign own_last  = req_last_i[owner_q];
    assign own_incr  = req_incr_i[int'(owner_q)*INCR_W +: INCR_W];
    assign sum       = {1'b0, acc_q} + (DATA_W+1)'(own_incr);

    // Scan downward so the smallest offset from ptr wins.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = N_REQ-1; i >= 0; i--) begin
            cand = {1'b0, ptr_q} + (ID_W+1)'(i);
            if (cand >= (ID_W+1)'(N_REQ)) begin
                cand = cand - (ID_W+1)'(N_REQ);
            end
            if (req_valid_i[cand[ID_W-1:0]]) begin
                found = 1'b1;
                pick  = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    owner_d = pick;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = ACC;
                end
            end
            ACC: begin
                if (own_valid) begin
                    ovf_d = ovf_q | sum[DATA_W];
`ifdef IOB_ACC_ARB_SATURATE_EN
                    acc_d = (sum[DATA_W] | ovf_q) ? '1 : sum[DATA_W-1:0];
`else
                    acc_d = sum[DATA_W-1:0];
`endif
                    if (own_last) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (res_ready_i) begin
                    ptr_d   = (owner_q == ID_W'(N_REQ-1)) ? '0
                                                          : owner_q + ID_W'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else if (cke_i) begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (state_q == ACC) begin
            req_ready_o[owner_q] = 1'b1;
        end
    end

    assign res_valid_o = (state_q == DONE);
    assign res_data_o  = acc_q;
    assign res_id_o    = owner_q;
    assign res_ovf_o   = ovf_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_iob_acc_arb.sv
// Randomized bench for iob_acc_arb against a job-level reference model.
// Honors IOB_ACC_ARB_SATURATE_EN in the expected sums.
module tb_iob_acc_arb;

    localparam int N    = 4;
    localparam int IW   = 8;
    localparam int DW   = 8;
    localparam int IDW  = 2;
    localparam int MAXV = (1 << DW) - 1;

    logic            clk = 1'b0;
    logic            cke;
    logic            arst_n;
    logic [N-1:0]    vld;
    logic [N-1:0]    lst;
    logic [N*IW-1:0] inc;
    logic [N-1:0]    rdy;
    logic            rv;
    logic            rr;
    logic [DW-1:0]   rd;
    logic [IDW-1:0]  rid;
    logic            rovf;
    logic            busy;

    always #5 clk = ~clk;

    iob_acc_arb #(
        .N_REQ (N),
        .INCR_W(IW),
        .DATA_W(DW)
    ) dut (
        .clk_i      (clk),
        .cke_i      (cke),
        .arst_n_i   (arst_n),
        .req_valid_i(vld),
        .req_last_i (lst),
        .req_incr_i (inc),
        .req_ready_o(rdy),
        .res_valid_o(rv),
        .res_ready_i(rr),
        .res_data_o (rd),
        .res_id_o   (rid),
        .res_ovf_o  (rovf),
        .busy_o     (busy)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    int unsigned job [N][$];
    int          pos [N];
    bit          started [N];
    int          exp_id [$];
    int          exp_dat [$];
    int          exp_ovf [$];
    int          res_cyc [$];
    int          m_ptr = 0;
    int          cyc = 0;
    int          t0 = 0;
    int          stall_pct = 0;
    int          cke_low = 0;
    int          rdy_pct = 100;
    bit          pv = 0;
    bit          phs = 0;
    logic [DW-1:0]  p_dat;
    logic [IDW-1:0] p_id;
    logic           p_ovf;

    function automatic void ref_job(input int k, output int s, output int o);
        s = 0;
        o = 0;
        for (int i = 0; i < job[k].size(); i++) begin
            s += int'(job[k][i]);
            if (s > MAXV) begin
                o = 1;
`ifdef IOB_ACC_ARB_SATURATE_EN
                s = MAXV;
`else
                s -= MAXV + 1;
`endif
            end
        end
    endfunction

    function automatic bit all_done();
        bit d;
        d = (exp_id.size() == 0);
        for (int k = 0; k < N; k++) begin
            if (pos[k] < job[k].size()) d = 0;
        end
        return d;
    endfunction

    function automatic void clear_model();
        for (int k = 0; k < N; k++) begin
            job[k].delete();
            pos[k]     = 0;
            started[k] = 0;
        end
        exp_id.delete();
        exp_dat.delete();
        exp_ovf.delete();
    endfunction

    // Grant order: first pending requester at or after ptr, cyclically.
    task automatic start_round(input logic [N-1:0] mask);
        int p;
        int j;
        int s;
        int o;
        bit hit;
        logic [N-1:0] pend;
        for (int k = 0; k < N; k++) begin
            if (!mask[k]) job[k].delete();
            pos[k]     = 0;
            started[k] = 0;
        end
        p    = m_ptr;
        pend = mask;
        while (pend != '0) begin
            hit = 0;
            for (int i = 0; i < N; i++) begin
                j = (p + i) % N;
                if (!hit && pend[j]) begin
                    hit = 1;
                    ref_job(j, s, o);
                    exp_id.push_back(j);
                    exp_dat.push_back(s);
                    exp_ovf.push_back(o);
                    pend[j] = 1'b0;
                    p = (j + 1) % N;
                end
            end
        end
        m_ptr = p;
        t0    = cyc;
        res_cyc.delete();
    endtask

    task automatic step();
        bit stall;
        @(negedge clk);
        cyc++;
        cke = ($urandom_range(99) >= cke_low);
        rr  = ($urandom_range(99) < rdy_pct);
        for (int k = 0; k < N; k++) begin
            stall = started[k] && ($urandom_range(99) < stall_pct);
            if (pos[k] < job[k].size() && !stall) begin
                vld[k]          = 1'b1;
                inc[k*IW +: IW] = IW'(job[k][pos[k]]);
                lst[k]          = (pos[k] == job[k].size() - 1);
            end else begin
                vld[k]          = 1'b0;
                inc[k*IW +: IW] = IW'($urandom);
                lst[k]          = 1'($urandom_range(1));
            end
        end
        #1;
        chk("rdy_onehot", 32'($countones(rdy) <= 1), 1);
        if (rv) begin
            chk("rdy_in_done", rdy, 0);
            if (pv && !phs) begin
                chk("hold_data", rd, p_dat);
                chk("hold_id", rid, p_id);
                chk("hold_ovf", rovf, p_ovf);
            end
        end
        phs = rv && rr && cke;
        if (phs) begin
            if (exp_id.size() == 0) begin
                chk("extra_res", 1, 0);
            end else begin
                chk("res_id", rid, exp_id.pop_front());
                chk("res_data", rd, exp_dat.pop_front());
                chk("res_ovf", rovf, exp_ovf.pop_front());
                res_cyc.push_back(cyc);
            end
        end
        pv    = rv;
        p_dat = rd;
        p_id  = rid;
        p_ovf = rovf;
        for (int k = 0; k < N; k++) begin
            if (vld[k] && rdy[k] && cke) begin
                pos[k]++;
                started[k] = 1;
            end
        end
    endtask

    task automatic run_round(input string tag);
        int n;
        n = 0;
        while (!all_done() && n < 3000) begin
            step();
            n++;
        end
        chk({tag, "_timeout"}, 32'(n < 3000), 1);
        if (n >= 3000) clear_model();
        step();
        chk({tag, "_idle"}, busy, 0);
    endtask

    task automatic knobs(input int s, input int c, input int r);
        stall_pct = s;
        cke_low   = c;
        rdy_pct   = r;
    endtask

    initial begin
        int n;
        logic [N-1:0] mask;
        cke    = 1'b1;
        arst_n = 1'b0;
        vld    = '0;
        lst    = '0;
        inc    = '0;
        rr     = 1'b0;
        #12;
        chk("rst_valid", rv, 0);
        chk("rst_ready", rdy, 0);
        chk("rst_data", rd, 0);
        chk("rst_id", rid, 0);
        chk("rst_ovf", rovf, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        arst_n = 1'b1;

        knobs(0, 0, 100);
        job[2] = '{5, 7, 9};
        start_round(4'b0100);
        run_round("t1");
        chk("t1_lat", res_cyc.size() ? res_cyc[0] - t0 : 0, 5);

        job[0] = '{1, 2};
        job[3] = '{3, 4};
        start_round(4'b1001);
        run_round("t2");
        chk("t2_lat", res_cyc.size() ? res_cyc[0] - t0 : 0, 4);
        chk("t2_period", res_cyc.size() > 1 ? res_cyc[1] - res_cyc[0] : 0, 4);

        job[0] = '{11};
        job[3] = '{12};
        start_round(4'b1001);
        run_round("t3");

        job[3] = '{1};
        start_round(4'b1000);
        run_round("t4");

        job[0] = '{20, 1};
        job[3] = '{30};
        start_round(4'b1001);
        run_round("t5");

        job[1] = '{200, 100};
        start_round(4'b0010);
        run_round("t6");

        knobs(0, 0, 0);
        job[1] = '{1, 2};
        start_round(4'b0010);
        n = 0;
        while (!rv && n < 20) begin
            step();
            n++;
        end
        chk("t7_reach", rv, 1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t7_valid", rv, 1);
            chk("t7_busy", busy, 1);
        end
        knobs(0, 0, 100);
        run_round("t7");

        knobs(50, 30, 100);
        job[2] = '{10, 20, 30, 40, 50};
        start_round(4'b0100);
        run_round("t8");

        knobs(0, 0, 100);
        job[1] = '{10, 20, 30, 40};
        start_round(4'b0010);
        n = 0;
        while (pos[1] < 2 && n < 50) begin
            step();
            n++;
        end
        @(posedge clk);
        #2;
        arst_n = 1'b0;
        #1;
        chk("t9_valid", rv, 0);
        chk("t9_ready", rdy, 0);
        chk("t9_data", rd, 0);
        chk("t9_id", rid, 0);
        chk("t9_ovf", rovf, 0);
        chk("t9_busy", busy, 0);
        clear_model();
        m_ptr = 0;
        vld   = '0;
        pv    = 0;
        phs   = 0;
        @(negedge clk);
        arst_n = 1'b1;

        job[2] = '{3, 4};
        job[3] = '{1};
        start_round(4'b1100);
        run_round("t10");

        for (int r = 0; r < 40; r++) begin
            knobs($urandom_range(50), $urandom_range(30),
                  $urandom_range(100, 20));
            mask = N'($urandom_range(15, 1));
            for (int k = 0; k < N; k++) begin
                job[k].delete();
                if (mask[k]) begin
                    n = $urandom_range(5, 1);
                    for (int b = 0; b < n; b++) begin
                        job[k].push_back($urandom_range(255));
                    end
                end
            end
            start_round(mask);
            run_round("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
